// File: rtl/elastic_stage_reg.sv
// -----------------------------------------------------------------------------
// elastic_stage_reg
//
// Two-entry elastic pipeline register (skid buffer) with valid/ready handshake
// on both sides. It is dropped between pipeline stages in place of a plain
// enable/clear register.
//
// in_ready is a flop output. It never depends combinationally on out_ready, so
// a stall moves upstream by one stage per cycle. The skid entry catches the
// beat that was already in flight when downstream stalled.
//
// A saturating counter records how many cycles the stage held valid data that
// downstream refused. This gives per-stage back-pressure profiling.
//
// Parameters
//   WIDTH      payload width in bits
//   CNT_W      stall counter width in bits
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; empties the stage and zeroes data/counter
//   flush      synchronous discard of every buffered entry (wins over all moves)
//   in_valid   upstream has a beat
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  stage presents a beat (registered)
//   out_ready  downstream accepts
//   out_data   head payload (registered)
//   occupancy  entries held: 0, 1 or 2
//   stall_cnt  saturating count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module elastic_stage_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // Encoding equals occupancy, which keeps the occupancy output trivial.
  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q,  main_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] stall_q,     stall_d;

  logic in_fire;
  logic out_fire;
  logic stall_cycle;

  // The handshakes use the registered ready/valid so that no input-to-output
  // combinational path exists through the stage.
  assign in_fire     = in_valid  & in_ready_q;
  assign out_fire    = out_valid_q & out_ready;
  assign stall_cycle = out_valid_q & ~out_ready;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d = S_ONE;
          main_d  = in_data;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;                 // head leaves, new beat takes its place
        end else if (in_fire) begin
          state_d = S_TWO;
          skid_d  = in_data;                // head is stuck, park the in-flight beat
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          state_d = S_ONE;
          main_d  = skid_q;                 // skid entry moves up to the head
        end
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase

    // The data registers may keep stale contents because out_valid masks them.
    if (flush) begin
      state_d = S_EMPTY;
    end
  end

  // Output flags are computed from the next state. After this they are held in
  // flops, so every output changes only on a clock edge or on reset.
  always_comb begin
    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (state_d != S_TWO);
  end

  // The counter saturates at all-ones. A flush does not clear it, and a flush
  // cycle still counts if the stall condition held in that cycle.
  always_comb begin
    stall_d = stall_q;
    if (stall_cycle && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_elastic_stage_reg.sv
module tb_elastic_stage_reg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;

  logic             in_ready,  s_in_ready;
  logic             out_valid, s_out_valid;
  logic [WIDTH-1:0] out_data,  s_out_data;
  logic [1:0]       occupancy, s_occupancy;
  logic [CNT_W-1:0] stall_cnt;
  logic [2:0]       s_stall_cnt;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  elastic_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy on the same stimulus, used for the saturation checks.
  elastic_stage_reg #(.WIDTH(WIDTH), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic r,
                           input logic [1:0] occ);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(r));
    chk({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
  endtask

  logic [WIDTH-1:0] q[$];
  int               exp_stall;
  int               exp_sat;
  logic             m_in_fire, m_out_fire;

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // ---- Reset / idle ----
    #3 reset = 1'b1;
    #1;
    chk_state("rst", 1'b0, 1'b1, 2'd0);
    chk("rst.stall", 64'(stall_cnt), 64'd0);
    chk("rst.data",  64'(out_data),  64'd0);
    @(negedge clk) reset = 1'b0;
    repeat (3) tick();
    chk_state("idle", 1'b0, 1'b1, 2'd0);
    chk("idle.stall", 64'(stall_cnt), 64'd0);

    // ---- Streaming 1..4 ----
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = WIDTH'(i);
      tick();
      chk($sformatf("stream%0d.data", i), 64'(out_data), 64'(i));
      chk_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
    end
    in_valid = 1'b0;
    tick();
    chk_state("stream.drain", 1'b0, 1'b1, 2'd0);
    chk("stream.stall", 64'(stall_cnt), 64'd0);

    // ---- Skid fill ----
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'hA;
    tick();
    chk_state("skid.one", 1'b1, 1'b1, 2'd1);
    chk("skid.one.stall", 64'(stall_cnt), 64'd0);
    in_data = 32'hB;
    tick();
    chk_state("skid.two", 1'b1, 1'b0, 2'd2);
    chk("skid.two.data",  64'(out_data),  64'hA);
    chk("skid.two.stall", 64'(stall_cnt), 64'd1);
    in_valid = 1'b0; in_data = 32'hFF;
    repeat (5) tick();
    chk("skid.hold.stall", 64'(stall_cnt), 64'd6);
    chk("skid.hold.data",  64'(out_data),  64'hA);
    chk_state("skid.hold", 1'b1, 1'b0, 2'd2);
    out_ready = 1'b1;
    #1 chk("skid.pop0.data", 64'(out_data), 64'hA);
    tick();
    chk("skid.pop1.data", 64'(out_data), 64'hB);
    chk_state("skid.pop1", 1'b1, 1'b1, 2'd1);
    tick();
    chk_state("skid.empty", 1'b0, 1'b1, 2'd0);
    chk("skid.end.stall", 64'(stall_cnt), 64'd6);

    // ---- Flush with a concurrent input ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    chk_state("flush.pre", 1'b1, 1'b0, 2'd2);
    chk("flush.pre.stall", 64'(stall_cnt), 64'd7);
    flush = 1'b1; in_data = 32'hC;
    tick();
    chk_state("flush.post", 1'b0, 1'b1, 2'd0);
    chk("flush.post.stall", 64'(stall_cnt), 64'd8);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk_state("flush.idle", 1'b0, 1'b1, 2'd0);
    chk("flush.idle.stall", 64'(stall_cnt), 64'd8);

    // ---- Async reset mid-transfer, then saturation ----
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h55; tick();
    in_valid = 1'b0;
    chk_state("arst.pre", 1'b1, 1'b1, 2'd1);
    #2 reset = 1'b1;
    #1;
    chk_state("arst", 1'b0, 1'b1, 2'd0);
    chk("arst.data",      64'(out_data),    64'd0);
    chk("arst.stall",     64'(stall_cnt),   64'd0);
    chk("arst.sat.stall", 64'(s_stall_cnt), 64'd0);
    @(negedge clk) reset = 1'b0;

    in_valid = 1'b1; in_data = 32'h5; tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("sat.reach", 64'(s_stall_cnt), 64'd7);
    repeat (3) tick();
    chk("sat.hold",  64'(s_stall_cnt), 64'd7);
    chk("sat.wide",  64'(stall_cnt),   64'd10);
    #2 reset = 1'b1;
    #1 chk("sat.reset", 64'(s_stall_cnt), 64'd0);
    @(negedge clk) reset = 1'b0;

    // ---- Random traffic against a depth-2 FIFO model ----
    exp_stall = 0;
    exp_sat   = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      flush     = 1'b0;
      m_in_fire  = in_valid && (q.size() < 2);
      m_out_fire = out_ready && (q.size() > 0);
      if (q.size() > 0 && !out_ready) begin
        if (exp_stall < 65535) exp_stall++;
        if (exp_sat < 7) exp_sat++;
      end
      tick();
      if (m_out_fire) void'(q.pop_front());
      if (m_in_fire)  q.push_back(in_data);
      chk("rnd.occ",   64'(occupancy), 64'(q.size()));
      chk("rnd.ready", 64'(in_ready),  64'(q.size() < 2));
      chk("rnd.valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) chk("rnd.data", 64'(out_data), 64'(q[0]));
      if (c % 100 == 99) begin
        chk("rnd.stall", 64'(stall_cnt),   64'(exp_stall));
        chk("rnd.sat",   64'(s_stall_cnt), 64'(exp_sat));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
